uart_cipher_bridge: RTL

UART_CIPHER_BRIDGE -- requirements
Module: uart_cipher_bridge

---
 rtl/uart_cipher_bridge.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cipher_bridge.sv
// UART front end for a block cipher engine: collects command+payload frames,
// loads keys or hands blocks to the engine, and serialises the engine result back out.
`timescale 1ns/1ps

module uart_cipher_bridge #(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD         = 9600,
    parameter int unsigned BLOCK_BYTES  = 8,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     uart_rx,
    output logic                     uart_tx,
    output logic [8*BLOCK_BYTES-1:0] key_out,
    output logic                     key_valid,
    output logic [8*BLOCK_BYTES-1:0] blk_data,
    output logic                     blk_mode,
    output logic                     blk_valid,
    input  logic                     blk_ready,
    input  logic [8*BLOCK_BYTES-1:0] res_data,
    input  logic                     res_valid,
    output logic                     err_frame,
    output logic                     err_cmd,
    output logic                     busy
);

    localparam int unsigned BIT_CNT = CLK_FREQ / BAUD;
    localparam int unsigned HALF    = BIT_CNT / 2;
    localparam int unsigned W       = 8 * BLOCK_BYTES;
    localparam int unsigned TO_CLKS = TIMEOUT_BITS * BIT_CNT;
    localparam int unsigned BC_W    = $clog2(BIT_CNT + 1);
    localparam int unsigned FB_W    = $clog2(BLOCK_BYTES + 1);
    localparam int unsigned TO_W    = $clog2(TO_CLKS + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
    typedef enum logic [2:0] {COLLECT, DISPATCH, ISSUE, WAIT, SEND} top_state_e;

    // ---------------- RX synchroniser and byte receiver ----------------
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [BC_W-1:0] rx_clk_q, rx_clk_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_done_c, rx_bad_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= IDLE;
            rx_clk_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_clk_q   <= rx_clk_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Start bit is re-checked at half a bit; every later sample is a full bit apart.
    always_comb begin : rx_next
        rx_state_d = rx_state_q;
        rx_clk_d   = rx_clk_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done_c  = 1'b0;
        rx_bad_c   = 1'b0;
        case (rx_state_q)
            IDLE: begin
                rx_clk_d = '0;
                rx_bit_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = START;
            end
            START: begin
                if (rx_clk_q == BC_W'(HALF - 1)) begin
                    rx_clk_d   = '0;
                    rx_state_d = rx_sync_q ? IDLE : DATA;
                end else begin
                    rx_clk_d = rx_clk_q + 1'b1;
                end
            end
            DATA: begin
                if (rx_clk_q == BC_W'(BIT_CNT - 1)) begin
                    rx_clk_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = STOP;
                end else begin
                    rx_clk_d = rx_clk_q + 1'b1;
                end
            end
            STOP: begin
                if (rx_clk_q == BC_W'(BIT_CNT - 1)) begin
                    rx_clk_d   = '0;
                    rx_state_d = IDLE;
                    rx_done_c  = rx_sync_q;
                    rx_bad_c   = !rx_sync_q;
                end else begin
                    rx_clk_d = rx_clk_q + 1'b1;
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    // ---------------- frame control, engine handshake and TX ----------------
    top_state_e      state_q, state_d;
    logic [FB_W-1:0] fcnt_q, fcnt_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [W-1:0]    payload_q, payload_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [W-1:0]    key_q, key_d;
    logic            key_valid_q, key_valid_d;
    logic [W-1:0]    blk_data_q, blk_data_d;
    logic            blk_mode_q, blk_mode_d;
    logic            blk_valid_q, blk_valid_d;
    logic            err_frame_q, err_frame_d;
    logic            err_cmd_q, err_cmd_d;
    logic            busy_q, busy_d;
    logic [W-1:0]    tx_data_q, tx_data_d;
    logic [BC_W-1:0] tx_clk_q, tx_clk_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [FB_W-1:0] tx_byte_q, tx_byte_d;
    logic            uart_tx_q, uart_tx_d;
    logic [7:0]      cur_byte_c;

    assign cur_byte_c = tx_data_q[W-1 -: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            fcnt_q      <= '0;
            cmd_q       <= '0;
            payload_q   <= '0;
            to_cnt_q    <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            blk_data_q  <= '0;
            blk_mode_q  <= 1'b0;
            blk_valid_q <= 1'b0;
            err_frame_q <= 1'b0;
            err_cmd_q   <= 1'b0;
            busy_q      <= 1'b0;
            tx_data_q   <= '0;
            tx_clk_q    <= '0;
            tx_bit_q    <= '0;
            tx_byte_q   <= '0;
            uart_tx_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            cmd_q       <= cmd_d;
            payload_q   <= payload_d;
            to_cnt_q    <= to_cnt_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            blk_data_q  <= blk_data_d;
            blk_mode_q  <= blk_mode_d;
            blk_valid_q <= blk_valid_d;
            err_frame_q <= err_frame_d;
            err_cmd_q   <= err_cmd_d;
            busy_q      <= busy_d;
            tx_data_q   <= tx_data_d;
            tx_clk_q    <= tx_clk_d;
            tx_bit_q    <= tx_bit_d;
            tx_byte_q   <= tx_byte_d;
            uart_tx_q   <= uart_tx_d;
        end
    end

    always_comb begin : top_next
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        cmd_d       = cmd_q;
        payload_d   = payload_q;
        to_cnt_d    = to_cnt_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        blk_data_d  = blk_data_q;
        blk_mode_d  = blk_mode_q;
        blk_valid_d = blk_valid_q;
        err_frame_d = 1'b0;
        err_cmd_d   = 1'b0;
        busy_d      = busy_q;
        tx_data_d   = tx_data_q;
        tx_clk_d    = tx_clk_q;
        tx_bit_d    = tx_bit_q;
        tx_byte_d   = tx_byte_q;
        uart_tx_d   = uart_tx_q;
        case (state_q)
            // Bytes only count here; the idle timer runs only on a partial frame.
            COLLECT: begin
                if (rx_done_c) begin
                    to_cnt_d = '0;
                    if (fcnt_q == '0) cmd_d = rx_shift_q;
                    else              payload_d = W'({payload_q, rx_shift_q});
                    if (fcnt_q == FB_W'(BLOCK_BYTES)) begin
                        fcnt_d  = '0;
                        state_d = DISPATCH;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end else if (rx_bad_c) begin
                    err_frame_d = 1'b1;
                    fcnt_d      = '0;
                    to_cnt_d    = '0;
                end else if (fcnt_q != '0 && rx_state_q == IDLE) begin
                    if (to_cnt_q == TO_W'(TO_CLKS - 1)) begin
                        err_frame_d = 1'b1;
                        fcnt_d      = '0;
                        to_cnt_d    = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end else begin
                    to_cnt_d = '0;
                end
            end
            DISPATCH: begin
                state_d = COLLECT;
                case (cmd_q)
                    8'hFF: begin
                        key_d       = payload_q;
                        key_valid_d = 1'b1;
                    end
                    8'h0F, 8'hF0: begin
                        state_d     = ISSUE;
                        blk_data_d  = payload_q;
                        blk_mode_d  = (cmd_q == 8'hF0);
                        blk_valid_d = 1'b1;
                        busy_d      = 1'b1;
                    end
                    default: err_cmd_d = 1'b1;
                endcase
            end
            ISSUE: begin
                if (blk_ready) begin
                    blk_valid_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (res_valid) begin
                    tx_data_d = res_data;
                    tx_clk_d  = '0;
                    tx_bit_d  = '0;
                    tx_byte_d = '0;
                    uart_tx_d = 1'b0;
                    state_d   = SEND;
                end
            end
            // Bit 0 is start, 1..8 data LSB first, 9 stop; next level is registered at bit end.
            SEND: begin
                if (tx_clk_q == BC_W'(BIT_CNT - 1)) begin
                    tx_clk_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        if (tx_byte_q == FB_W'(BLOCK_BYTES - 1)) begin
                            uart_tx_d = 1'b1;
                            busy_d    = 1'b0;
                            state_d   = COLLECT;
                        end else begin
                            tx_byte_d = tx_byte_q + 1'b1;
                            tx_bit_d  = '0;
                            tx_data_d = W'({tx_data_q, 8'h00});
                            uart_tx_d = 1'b0;
                        end
                    end else begin
                        tx_bit_d  = tx_bit_q + 1'b1;
                        uart_tx_d = (tx_bit_q == 4'd8) ? 1'b1 : cur_byte_c[tx_bit_q[2:0]];
                    end
                end else begin
                    tx_clk_d = tx_clk_q + 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign uart_tx   = uart_tx_q;
    assign key_out   = key_q;
    assign key_valid = key_valid_q;
    assign blk_data  = blk_data_q;
    assign blk_mode  = blk_mode_q;
    assign blk_valid = blk_valid_q;
    assign err_frame = err_frame_q;
    assign err_cmd   = err_cmd_q;
    assign busy      = busy_q;

endmodule
